mcpu_core_param: RTL

//  Parametrised successor to the 6-bit-instruction accumulator CPU core on the tiny-tapeout pin budget.

---
 rtl/mcpu_pkg.sv | 41 ++++
 rtl/mcpu_core_param_if.sv | 23 ++
 rtl/mcpu_regfile.sv | 31 +++
 rtl/mcpu_core_param.sv | 112 +++++++++++
 4 files changed

// File: rtl/mcpu_pkg.sv
// Shared opcode fields and the instruction decoder for the parametrised accumulator core.
package mcpu_pkg;

  localparam logic [1:0] OP_BCC  = 2'b00;
  localparam logic [1:0] OP_LDI  = 2'b01;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_STA  = 3'b101;
  localparam logic [2:0] OP_LDA  = 3'b110;
  localparam logic [5:0] OP_NOT  = 6'b111000;
  localparam logic [5:0] OP_OUT  = 6'b111001;
  localparam logic [5:0] OP_JMPA = 6'b111010;
  localparam logic [5:0] OP_RRC  = 6'b111011;

  typedef enum logic [9:0] {
    OPK_BCC  = 10'b00_0000_0001,
    OPK_LDI  = 10'b00_0000_0010,
    OPK_ADD  = 10'b00_0000_0100,
    OPK_STA  = 10'b00_0000_1000,
    OPK_LDA  = 10'b00_0001_0000,
    OPK_NOT  = 10'b00_0010_0000,
    OPK_OUT  = 10'b00_0100_0000,
    OPK_JMPA = 10'b00_1000_0000,
    OPK_RRC  = 10'b01_0000_0000,
    OPK_NOP  = 10'b10_0000_0000
  } op_e;

  // 1111xx is reserved and falls through to NOP
  function automatic op_e mcpu_decode(input logic [5:0] inst);
    if (inst[5:4] == OP_BCC)       return OPK_BCC;
    else if (inst[5:4] == OP_LDI)  return OPK_LDI;
    else if (inst[5:3] == OP_ADD)  return OPK_ADD;
    else if (inst[5:3] == OP_STA)  return OPK_STA;
    else if (inst[5:3] == OP_LDA)  return OPK_LDA;
    else if (inst == OP_NOT)       return OPK_NOT;
    else if (inst == OP_OUT)       return OPK_OUT;
    else if (inst == OP_JMPA)      return OPK_JMPA;
    else if (inst == OP_RRC)       return OPK_RRC;
    else                           return OPK_NOP;
  endfunction

endpackage

// File: rtl/mcpu_core_param_if.sv
// Instruction input and architectural state outputs of the core, bundled for the pin wrapper.
interface mcpu_core_param_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PC_W   = 8
);
  logic [5:0]        inst_in;
  logic              inst_valid;
  logic [PC_W-1:0]   pc_o;
  logic [DATA_W-1:0] accu_o;
  logic              carry_o;
  logic [DATA_W-1:0] port_o;
  logic              port_stb;

  modport master (
    output inst_in, inst_valid,
    input  pc_o, accu_o, carry_o, port_o, port_stb
  );

  modport slave (
    input  inst_in, inst_valid,
    output pc_o, accu_o, carry_o, port_o, port_stb
  );
endinterface

// File: rtl/mcpu_regfile.sv
// Register file: synchronous write, combinational read, async clear; addresses >= REG_DEPTH are void.
module mcpu_regfile #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned REG_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [2:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [2:0]        raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] regs [REG_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < REG_DEPTH; i++)
        if (we && waddr == 3'(i)) regs[i] <= wdata;
    end
  end

  // Full 3-bit compare, so out-of-range addresses neither alias nor read stale data
  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < REG_DEPTH; i++)
      if (raddr == 3'(i)) rdata = regs[i];
  end
endmodule

// File: rtl/mcpu_core_param.sv
// Parametrised 6-bit-instruction accumulator core: decode, ALU, pc/carry/LDI-nibble/port state.
module mcpu_core_param
  import mcpu_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned PC_W      = 8,
  parameter int unsigned REG_DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  mcpu_core_param_if.slave bus
);
  localparam int unsigned NNIB = DATA_W / 4;
  localparam int unsigned NW   = $clog2(NNIB);

  logic [PC_W-1:0]   pc, pc_n;
  logic [DATA_W-1:0] accu, accu_n;
  logic              carry, carry_n;
  logic [NW-1:0]     nib_idx, nib_n;
  logic [DATA_W-1:0] port, port_n;
  logic              stb, stb_n;

  logic [3:0]        imm;
  op_e               op;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] ldi_val;
  logic              reg_we;

  assign imm = bus.inst_in[3:0];
  assign op  = mcpu_decode(bus.inst_in);

  mcpu_regfile #(
    .DATA_W   (DATA_W),
    .REG_DEPTH(REG_DEPTH)
  ) u_regfile (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (reg_we),
    .waddr(bus.inst_in[2:0]),
    .wdata(accu),
    .raddr(bus.inst_in[2:0]),
    .rdata(rdata)
  );

  // Nibble k gets imm, nibbles above get imm's sign, nibbles below keep their value
  always_comb begin
    ldi_val = accu;
    for (int unsigned n = 0; n < NNIB; n++) begin
      if (n == 32'(nib_idx))     ldi_val[4*n +: 4] = imm;
      else if (n > 32'(nib_idx)) ldi_val[4*n +: 4] = {4{imm[3]}};
    end
  end

  always_comb begin
    pc_n    = pc;
    accu_n  = accu;
    carry_n = carry;
    nib_n   = nib_idx;
    port_n  = port;
    stb_n   = 1'b0;
    reg_we  = 1'b0;
    if (bus.inst_valid) begin
      pc_n  = pc + PC_W'(1);
      nib_n = '0;
      unique case (op)
        OPK_BCC: begin
          carry_n = 1'b0;
          if (!carry) pc_n = pc + PC_W'($signed(imm));
        end
        OPK_LDI: begin
          accu_n = ldi_val;
          nib_n  = (nib_idx == NW'(NNIB - 1)) ? '0 : nib_idx + NW'(1);
        end
        OPK_ADD:  {carry_n, accu_n} = {1'b0, accu} + {1'b0, rdata};
        OPK_STA:  reg_we = 1'b1;
        OPK_LDA:  accu_n = rdata;
        OPK_NOT:  accu_n = ~accu;
        OPK_OUT: begin
          port_n = accu;
          stb_n  = 1'b1;
        end
        OPK_JMPA: pc_n = PC_W'(accu);
        OPK_RRC:  {accu_n, carry_n} = {carry, accu};
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= '0;
      accu    <= '0;
      carry   <= 1'b0;
      nib_idx <= '0;
      port    <= '0;
      stb     <= 1'b0;
    end else begin
      pc      <= pc_n;
      accu    <= accu_n;
      carry   <= carry_n;
      nib_idx <= nib_n;
      port    <= port_n;
      stb     <= stb_n;
    end
  end

  assign bus.pc_o     = pc;
  assign bus.accu_o   = accu;
  assign bus.carry_o  = carry;
  assign bus.port_o   = port;
  assign bus.port_stb = stb;
endmodule
